// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   fetch_state_e    : fetch FSM states (RUN issues requests, FLUSH drains stale responses)
//   PC_INCR          : sequential PC step in bytes
//   DEFAULT_RESET_PC : default program counter after reset
//   fetch_entry_t    : buffered instruction word together with the PC it was fetched from
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int PC_INCR    = 4;

  localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] inst;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory.
//   imem_req_valid / imem_req_ready / imem_req_addr : pipelined fetch request
//   imem_rsp_valid / imem_rsp_data                  : in-order response, no backpressure
// master = fetch unit, slave = memory.
interface fetch_pc_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of entry_t with push, pop, flush and occupancy count.
//   clk, reset        : clock and synchronous active-high reset
//   flush             : empties the FIFO on the next edge (wins over push/pop)
//   push, push_entry  : write an entry (ignored when full unless popping the same cycle)
//   pop               : drop the head (ignored when empty)
//   head              : current head entry, all-zero while empty
//   count             : number of stored entries
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     push_entry,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_n_s;
  logic [PW-1:0]   wr_ptr_n_s;
  logic [PW-1:0]   rd_ptr_n_s;
  logic            do_push_s;
  logic            do_pop_s;

  // Qualify push/pop against occupancy and compute wrapped pointers and next count.
  always_comb begin
    do_pop_s   = pop && (count_r != '0);
    do_push_s  = push && ((count_r < DEPTH_C) || do_pop_s);
    wr_ptr_n_s = (wr_ptr_r == LAST_C) ? '0 : wr_ptr_r + PW'(1);
    rd_ptr_n_s = (rd_ptr_r == LAST_C) ? '0 : rd_ptr_r + PW'(1);
    case ({do_push_s, do_pop_s})
      2'b10:   count_n_s = count_r + CW'(1);
      2'b01:   count_n_s = count_r - CW'(1);
      default: count_n_s = count_r;
    endcase
  end

  // Storage, pointers and occupancy; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= wr_ptr_n_s;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_n_s;
      end
      count_r <= count_n_s;
    end
  end

  // Head is forced to zero while empty so stale entries never leak out.
  always_comb begin
    if (count_r != '0) begin
      head = mem_r[rd_ptr_r];
    end else begin
      head = '0;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch front end.
//   clk, reset            : clock and synchronous active-high reset
//   redirect_valid/_addr  : load a new fetch PC (low two bits forced to zero) and flush
//   imem (master)         : pipelined request / in-order response bus to instruction memory
//   inst_valid/inst_ready : valid/ready hand-off of buffered instructions to decode
//   inst_data/inst_pc/inst_pcplus4 : head instruction, its PC, and PC+4 (wrapping)
// Requests are credit limited so outstanding plus buffered fetches never exceed
// BUF_DEPTH; responses therefore always find room in the buffer.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_addr,
  fetch_pc_unit_if.master       imem,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic [DATA_WIDTH-1:0] inst_pcplus4
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]           CREDIT_C = (CW + 1)'(BUF_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(PC_INCR);
  localparam logic [DATA_WIDTH-1:0] ALIGN_M  = ~(DATA_WIDTH'(3));

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  fetch_state_e          state_r, state_n_s;
  logic [DATA_WIDTH-1:0] pc_r, pc_n_s;
  logic [CW-1:0]         inflight_r, inflight_n_s;
  logic [CW-1:0]         drop_cnt_r, drop_cnt_n_s;
  logic [CW-1:0]         buf_count_s;
  logic [CW-1:0]         tag_count_s;
  logic [CW:0]           credit_used_s;
  logic [DATA_WIDTH-1:0] tag_head_s;
  logic [DATA_WIDTH-1:0] redirect_pc_s;
  logic                  req_valid_s;
  logic                  req_fire_s;
  logic                  rsp_take_s;
  logic                  rsp_keep_s;
  logic                  pop_s;
  entry_t                push_entry_s;
  entry_t                head_entry_s;

  // Request qualification and response classification.
  always_comb begin
    redirect_pc_s = redirect_addr & ALIGN_M;
    credit_used_s = {1'b0, inflight_r} + {1'b0, buf_count_s};
    req_valid_s   = !reset && (state_r == RUN) && !redirect_valid && (credit_used_s < CREDIT_C);
    req_fire_s    = req_valid_s && imem.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_take_s    = imem.imem_rsp_valid && (inflight_r != '0);
    // Kept only when it belongs to a live request; redirect or pending drops discard it.
    rsp_keep_s    = rsp_take_s && (drop_cnt_r == '0) && !redirect_valid && (tag_count_s != '0);
    pop_s         = inst_valid && inst_ready;
    push_entry_s.inst = imem.imem_rsp_data;
    push_entry_s.pc   = tag_head_s;
  end

  // Next-state, PC and counter logic; redirect overrides the sequential path.
  always_comb begin
    state_n_s    = state_r;
    pc_n_s       = pc_r;
    drop_cnt_n_s = drop_cnt_r;
    inflight_n_s = inflight_r + CW'(req_fire_s) - CW'(rsp_take_s);
    if (redirect_valid) begin
      pc_n_s       = redirect_pc_s;
      // Everything still outstanding after this cycle's response is stale.
      drop_cnt_n_s = inflight_r - CW'(rsp_take_s);
      state_n_s    = (drop_cnt_n_s != '0) ? FLUSH : RUN;
    end else begin
      if (req_fire_s) begin
        pc_n_s = pc_r + PC_STEP;
      end else begin
        pc_n_s = pc_r;
      end
      if (rsp_take_s && (drop_cnt_r != '0)) begin
        drop_cnt_n_s = drop_cnt_r - CW'(1);
      end else begin
        drop_cnt_n_s = drop_cnt_r;
      end
      case (state_r)
        RUN:     state_n_s = RUN;
        FLUSH:   state_n_s = (drop_cnt_r == '0) ? RUN : FLUSH;
        default: state_n_s = RUN;
      endcase
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RUN;
      pc_r       <= RESET_PC;
      inflight_r <= '0;
      drop_cnt_r <= '0;
    end else begin
      state_r    <= state_n_s;
      pc_r       <= pc_n_s;
      inflight_r <= inflight_n_s;
      drop_cnt_r <= drop_cnt_n_s;
    end
  end

  // PC tags of live requests, consumed in order by kept responses.
  fetch_buffer #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (logic [DATA_WIDTH-1:0])
  ) u_tag_q (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (req_fire_s),
    .push_entry (pc_r),
    .pop        (rsp_keep_s),
    .head       (tag_head_s),
    .count      (tag_count_s)
  );

  // Returned instructions waiting for decode.
  fetch_buffer #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (entry_t)
  ) u_inst_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (rsp_keep_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_entry_s),
    .count      (buf_count_s)
  );

  // Decode-side outputs come straight from buffer registers.
  always_comb begin
    inst_valid = (buf_count_s != '0);
    inst_data  = head_entry_s.inst;
    inst_pc    = head_entry_s.pc;
    if (inst_valid) begin
      inst_pcplus4 = head_entry_s.pc + PC_STEP;
    end else begin
      inst_pcplus4 = '0;
    end
  end

  assign imem.imem_req_valid = req_valid_s;
  assign imem.imem_req_addr  = pc_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcplus4;

  fetch_pc_unit_if #(.DATA_WIDTH(32)) imem ();

  fetch_pc_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .BUF_DEPTH  (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem           (imem),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_pcplus4   (inst_pcplus4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // memory model state and observation logs
  logic [31:0] pend[$];
  logic [31:0] fire_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_data[$];
  logic [31:0] pop_p4[$];
  bit          hold   = 1'b0;
  bit          inject = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic clear_logs();
    fire_log.delete();
    pop_pc.delete();
    pop_data.delete();
    pop_p4.delete();
  endtask

  // one clock: observe handshakes before the edge, then play memory after it
  task automatic tick();
    bit          fired;
    logic [31:0] fa;
    #1;
    fired = imem.imem_req_valid && imem.imem_req_ready;
    fa    = imem.imem_req_addr;
    if (inst_valid && inst_ready) begin
      pop_pc.push_back(inst_pc);
      pop_data.push_back(inst_data);
      pop_p4.push_back(inst_pcplus4);
    end
    @(posedge clk);
    #1;
    if (fired) begin
      pend.push_back(fa);
      fire_log.push_back(fa);
    end
    if (!hold && pend.size() > 0) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = inst_of(pend.pop_front());
    end else if (inject) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = 32'hBAD0_BAD0;
      inject = 1'b0;
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = 32'h0000_0000;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    hold  = 1'b0;
    reset = 1'b1;
    ticks(3);
    pend.delete();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_addr = 32'h0;
    inst_ready = 1'b0; imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = 32'h0;
    ticks(2);
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %h want 0", inst_valid); else n_pass++;
    n_checks++; if (inst_data !== 32'h0) $display("FAIL reset_inst_data got %h want 0", inst_data); else n_pass++;
    n_checks++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc got %h want 0", inst_pc); else n_pass++;
    n_checks++; if (inst_pcplus4 !== 32'h0) $display("FAIL reset_pcplus4 got %h want 0", inst_pcplus4); else n_pass++;
    n_checks++; if (imem.imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %h want 0", imem.imem_req_valid); else n_pass++;
  endtask

  task automatic test_sequential();
    inst_ready = 1'b1;
    reset = 1'b0;
    clear_logs();
    #1;
    n_checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h0) $display("FAIL seq_c0_req got v=%h a=%h want v=1 a=0", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    tick();
    n_checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h4) $display("FAIL seq_c1_req got v=%h a=%h want v=1 a=4", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL seq_c1_inst_valid got %h want 0", inst_valid); else n_pass++;
    tick();
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL seq_c2_inst_valid got %h want 1", inst_valid); else n_pass++;
    n_checks++; if (inst_pc !== 32'h0 || inst_pcplus4 !== 32'h4) $display("FAIL seq_c2_pc got %h/%h want 0/4", inst_pc, inst_pcplus4); else n_pass++;
    n_checks++; if (inst_data !== 32'hC0DE_0013) $display("FAIL seq_c2_data got %h want c0de0013", inst_data); else n_pass++;
    ticks(12);
    n_checks++; if (pop_pc.size() < 4 || fire_log.size() < 4) $display("FAIL seq_count got pops=%0d fires=%0d want >=4", pop_pc.size(), fire_log.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (pop_pc[i] !== 32'(4*i) || pop_p4[i] !== 32'(4*i+4)) $display("FAIL seq_pop%0d got pc=%h p4=%h want %h/%h", i, pop_pc[i], pop_p4[i], 4*i, 4*i+4); else n_pass++;
      n_checks++; if (fire_log[i] !== 32'(4*i)) $display("FAIL seq_req%0d got %h want %h", i, fire_log[i], 4*i); else n_pass++;
    end
  endtask

  task automatic test_stall();
    inst_ready = 1'b0;
    do_reset();
    ticks(6);
    n_checks++; if (fire_log.size() != 2) $display("FAIL stall_req_count got %0d want 2", fire_log.size()); else n_pass++;
    n_checks++; if (fire_log[0] !== 32'h0 || fire_log[1] !== 32'h4) $display("FAIL stall_req_addrs got %h,%h want 0,4", fire_log[0], fire_log[1]); else n_pass++;
    n_checks++; if (imem.imem_req_valid !== 1'b0) $display("FAIL stall_req_valid got %h want 0", imem.imem_req_valid); else n_pass++;
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) $display("FAIL stall_head got v=%h pc=%h want 1/0", inst_valid, inst_pc); else n_pass++;
    inst_ready = 1'b1;
    ticks(8);
    n_checks++; if (pop_pc.size() < 3) $display("FAIL stall_pop_count got %0d want >=3", pop_pc.size()); else n_pass++;
    n_checks++; if (pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8) $display("FAIL stall_pops got %h,%h,%h want 0,4,8", pop_pc[0], pop_pc[1], pop_pc[2]); else n_pass++;
    n_checks++; if (pop_data[1] !== 32'hC0DE_0017) $display("FAIL stall_data1 got %h want c0de0017", pop_data[1]); else n_pass++;
  endtask

  task automatic test_redirect_flush();
    inst_ready = 1'b1;
    do_reset();
    hold = 1'b1;
    ticks(3);
    n_checks++; if (fire_log.size() != 2) $display("FAIL flush_inflight got %0d want 2", fire_log.size()); else n_pass++;
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0100;
    #1;
    n_checks++; if (imem.imem_req_valid !== 1'b0) $display("FAIL flush_redirect_req got %h want 0", imem.imem_req_valid); else n_pass++;
    tick();
    redirect_valid = 1'b0; hold = 1'b0;
    clear_logs();
    n_checks++; if (imem.imem_req_valid !== 1'b0 || imem.imem_req_addr !== 32'h100) $display("FAIL flush_pc got v=%h a=%h want 0/100", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    ticks(3);
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL flush_drop got inst_valid=%h want 0", inst_valid); else n_pass++;
    ticks(8);
    n_checks++; if (fire_log.size() < 1 || fire_log[0] !== 32'h100) $display("FAIL flush_first_req got %h want 100", fire_log[0]); else n_pass++;
    n_checks++; if (pop_pc.size() < 2) $display("FAIL flush_pop_count got %0d want >=2", pop_pc.size()); else n_pass++;
    n_checks++; if (pop_pc[0] !== 32'h100 || pop_pc[1] !== 32'h104) $display("FAIL flush_pops got %h,%h want 100,104", pop_pc[0], pop_pc[1]); else n_pass++;
    n_checks++; if (pop_data[0] !== 32'hC0DE_0113) $display("FAIL flush_data got %h want c0de0113", pop_data[0]); else n_pass++;
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0203;
    #1;
    n_checks++; if (imem.imem_req_valid !== 1'b0) $display("FAIL align_redirect_req got %h want 0", imem.imem_req_valid); else n_pass++;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    n_checks++; if (imem.imem_req_addr !== 32'h200) $display("FAIL align_pc got %h want 200", imem.imem_req_addr); else n_pass++;
    ticks(8);
    n_checks++; if (fire_log.size() < 1 || fire_log[0] !== 32'h200) $display("FAIL align_req got %h want 200", fire_log[0]); else n_pass++;
    n_checks++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h200 || pop_p4[0] !== 32'h204) $display("FAIL align_pop got %h/%h want 200/204", pop_pc[0], pop_p4[0]); else n_pass++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    ticks(10);
    n_checks++; if (fire_log.size() < 2) $display("FAIL wrap_req_count got %0d want >=2", fire_log.size()); else n_pass++;
    n_checks++; if (fire_log[0] !== 32'hFFFF_FFFC || fire_log[1] !== 32'h0) $display("FAIL wrap_reqs got %h,%h want fffffffc,0", fire_log[0], fire_log[1]); else n_pass++;
    n_checks++; if (pop_pc.size() < 2) $display("FAIL wrap_pop_count got %0d want >=2", pop_pc.size()); else n_pass++;
    n_checks++; if (pop_pc[0] !== 32'hFFFF_FFFC || pop_p4[0] !== 32'h0) $display("FAIL wrap_pop0 got %h/%h want fffffffc/0", pop_pc[0], pop_p4[0]); else n_pass++;
    n_checks++; if (pop_pc[1] !== 32'h0 || pop_p4[1] !== 32'h4) $display("FAIL wrap_pop1 got %h/%h want 0/4", pop_pc[1], pop_p4[1]); else n_pass++;
  endtask

  task automatic test_midreset();
    inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    ticks(8);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) $display("FAIL midrst_full got v=%h pc=%h want 1/40", inst_valid, inst_pc); else n_pass++;
    reset = 1'b1; inject = 1'b1;
    tick();
    n_checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0) $display("FAIL midrst_flushed got v=%h pc=%h want 0/0", inst_valid, inst_pc); else n_pass++;
    n_checks++; if (imem.imem_req_valid !== 1'b0) $display("FAIL midrst_req got %h want 0", imem.imem_req_valid); else n_pass++;
    tick();
    pend.delete();
    reset = 1'b0; imem.imem_req_ready = 1'b0; inject = 1'b1;
    ticks(2);
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL midrst_stale got inst_valid=%h want 0", inst_valid); else n_pass++;
    n_checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h0) $display("FAIL midrst_req_pc got v=%h a=%h want 1/0", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    imem.imem_req_ready = 1'b1; inst_ready = 1'b1;
    clear_logs();
    ticks(6);
    n_checks++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0 || pop_data[0] !== 32'hC0DE_0013) $display("FAIL midrst_first got pc=%h d=%h want 0/c0de0013", pop_pc[0], pop_data[0]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_flush();
    test_misaligned();
    test_wrap();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
